// File: rtl/rf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared constants and helpers for the register-file write arbiter:
//   - requester indices (0 = ALU writeback, 1 = load unit)
//   - number of requesters and per-requester queue depth
//   - grant enum and the round-robin pick function
// ---------------------------------------------------------------------------
package rf_write_arbiter_pkg;

  localparam int NUM_REQ    = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;

  typedef enum logic {
    GNT_ALU  = 1'b0,
    GNT_LOAD = 1'b1
  } gnt_e;

  // Alternate on contention; otherwise serve whichever queue has work.
  // With nothing pending the result is don't-care (caller qualifies it).
  function automatic gnt_e pick_grant(input logic ne0, input logic ne1,
                                      input gnt_e last);
    gnt_e g;
    if (ne0 && ne1) begin
      g = (last == GNT_ALU) ? GNT_LOAD : GNT_ALU;
    end else if (ne1) begin
      g = GNT_LOAD;
    end else begin
      g = GNT_ALU;
    end
    return g;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the two requester handshakes and the register-file write port.
//   reqN_valid/reqN_dest/reqN_data : requester -> arbiter
//   reqN_ready                     : arbiter -> requester
//   write_enable/dest/data_in      : arbiter -> register file
//   busy                           : per-register pending-write flags
// modport master : requester/regfile side (testbench)
// modport slave  : arbiter side
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                   req0_valid;
  logic                   req0_ready;
  logic [ADDR_W-1:0]      req0_dest;
  logic [DATA_W-1:0]      req0_data;
  logic                   req1_valid;
  logic                   req1_ready;
  logic [ADDR_W-1:0]      req1_dest;
  logic [DATA_W-1:0]      req1_data;
  logic                   write_enable;
  logic [ADDR_W-1:0]      dest;
  logic [DATA_W-1:0]      data_in;
  logic [2**ADDR_W-1:0]   busy;

  modport master (
    output req0_valid, req0_dest, req0_data,
    output req1_valid, req1_dest, req1_data,
    input  req0_ready, req1_ready,
    input  write_enable, dest, data_in, busy
  );

  modport slave (
    input  req0_valid, req0_dest, req0_data,
    input  req1_valid, req1_dest, req1_data,
    output req0_ready, req1_ready,
    output write_enable, dest, data_in, busy
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo
// Small per-requester write-back queue (depth from the package).
// Ports:
//   clk, rst       : clock, synchronous active-high reset (empties queue)
//   push_i         : requester valid
//   push_dest_i/_data_i : entry to enqueue
//   ready_o        : queue can accept (not full, not in reset)
//   pop_i          : remove head at end of this cycle
//   nempty_o       : at least one entry held
//   head_dest_o/head_data_o : oldest entry
//   busy_o         : one-hot-or of destinations of all held entries
// ---------------------------------------------------------------------------
module rf_wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [ADDR_W-1:0]    push_dest_i,
  input  logic [DATA_W-1:0]    push_data_i,
  output logic                 ready_o,
  input  logic                 pop_i,
  output logic                 nempty_o,
  output logic [ADDR_W-1:0]    head_dest_o,
  output logic [DATA_W-1:0]    head_data_o,
  output logic [2**ADDR_W-1:0] busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] dest_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic              accept, pop;
  logic [IDX_W-1:0]  wr_idx;

  // Readiness looks only at current occupancy: a full queue refuses even
  // when its head leaves this cycle.
  assign ready_o  = (count_q < FULL_CNT) && !rst;
  assign nempty_o = (count_q != '0);
  assign accept   = push_i && ready_o;
  assign pop      = pop_i && nempty_o;
  // Slot for the new entry after the optional shift caused by a pop.
  assign wr_idx   = IDX_W'(count_q - CNT_W'(pop));

  always_comb begin
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is a shift queue: head is always slot 0. A write to the same
  // slot as the shift target overrides the shifted value.
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        dest_q[i] <= dest_q[i+1];
        data_q[i] <= data_q[i+1];
      end
    end
    if (accept) begin
      dest_q[wr_idx] <= push_dest_i;
      data_q[wr_idx] <= push_data_i;
    end
  end

  assign head_dest_o = dest_q[0];
  assign head_data_o = data_q[0];

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        busy_o[dest_q[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Merges register-file writes from the ALU writeback (requester 0) and the
// load unit (requester 1) onto a single write port. Each requester has a
// small queue; one head is written per cycle with round-robin priority on
// contention, and busy[] flags every register with a queued write.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   wb   : rf_write_arbiter_if.slave (requests, ready, write port, busy)
// Build option:
//   RF_ZERO_REG_EN : register 0 is hardwired; writes to it are drained
//                    without a write strobe and busy[0] stays low.
// ---------------------------------------------------------------------------
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_write_arbiter_if.slave    wb
);

  logic                 ne0, ne1;
  logic                 pop0, pop1;
  logic [ADDR_W-1:0]    hd_dest0, hd_dest1, head_dest;
  logic [DATA_W-1:0]    hd_data0, hd_data1, head_data;
  logic [2**ADDR_W-1:0] busy0, busy1, busy_all;
  gnt_e                 last_q, last_d, gnt;
  logic                 gnt_vld;

  rf_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo_alu (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wb.req0_valid),
    .push_dest_i (wb.req0_dest),
    .push_data_i (wb.req0_data),
    .ready_o     (wb.req0_ready),
    .pop_i       (pop0),
    .nempty_o    (ne0),
    .head_dest_o (hd_dest0),
    .head_data_o (hd_data0),
    .busy_o      (busy0)
  );

  rf_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo_load (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wb.req1_valid),
    .push_dest_i (wb.req1_dest),
    .push_data_i (wb.req1_data),
    .ready_o     (wb.req1_ready),
    .pop_i       (pop1),
    .nempty_o    (ne1),
    .head_dest_o (hd_dest1),
    .head_data_o (hd_data1),
    .busy_o      (busy1)
  );

  // Grant state: last_grant starts at LOAD so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_LOAD;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt     = pick_grant(ne0, ne1, last_q);
    gnt_vld = (ne0 || ne1) && !rst;
    last_d  = last_q;
    if (gnt_vld) begin
      last_d = gnt;
    end
  end

  assign pop0      = gnt_vld && (gnt == GNT_ALU);
  assign pop1      = gnt_vld && (gnt == GNT_LOAD);
  assign head_dest = (gnt == GNT_ALU) ? hd_dest0 : hd_dest1;
  assign head_data = (gnt == GNT_ALU) ? hd_data0 : hd_data1;

  always_comb begin
    wb.write_enable = 1'b0;
    wb.dest         = '0;
    wb.data_in      = '0;
    if (gnt_vld) begin
      wb.dest    = head_dest;
      wb.data_in = head_data;
`ifdef RF_ZERO_REG_EN
      wb.write_enable = (head_dest != '0);
`else
      wb.write_enable = 1'b1;
`endif
    end
  end

  always_comb begin
    busy_all = busy0 | busy1;
`ifdef RF_ZERO_REG_EN
    busy_all[0] = 1'b0;
`endif
    wb.busy = rst ? '0 : busy_all;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
`timescale 1ns/1ps
module tb_rf_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 2**ADDR_W;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    bit   we;
    ent_t e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t m_q0[$];
  ent_t m_q1[$];
  int   m_last = 1;
  exp_t exp_q[$];
  ent_t wlog[$];
  logic rdy0_s, rdy1_s;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: two bounded queues, round-robin on contention.
  function automatic int model_pick();
    if (m_q0.size() > 0 && m_q1.size() > 0) return (m_last == 0) ? 1 : 0;
    if (m_q0.size() > 0) return 0;
    if (m_q1.size() > 0) return 1;
    return -1;
  endfunction

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] b;
    b = '0;
    foreach (m_q0[i]) b[m_q0[i].dest] = 1'b1;
    foreach (m_q1[i]) b[m_q1[i].dest] = 1'b1;
    if (ZERO_EN) b[0] = 1'b0;
    return b;
  endfunction

  function automatic void push_exp(input ent_t e);
    exp_t x;
    x.e  = e;
    x.we = !(ZERO_EN && e.dest == '0);
    exp_q.push_back(x);
  endfunction

  // Model update at each edge, then predict what the DUT presents next cycle.
  always @(posedge clk) begin
    bit a0, a1;
    int g;
    a0 = (bus.req0_valid === 1'b1) && (m_q0.size() < 2) && !rst;
    a1 = (bus.req1_valid === 1'b1) && (m_q1.size() < 2) && !rst;
    if (rst) begin
      m_q0.delete();
      m_q1.delete();
      m_last = 1;
    end else begin
      g = model_pick();
      if (g == 0) void'(m_q0.pop_front());
      else if (g == 1) void'(m_q1.pop_front());
      if (g >= 0) m_last = g;
      if (a0) m_q0.push_back('{bus.req0_dest, bus.req0_data});
      if (a1) m_q1.push_back('{bus.req1_dest, bus.req1_data});
    end
    g = model_pick();
    if (g == 0) push_exp(m_q0[0]);
    else if (g == 1) push_exp(m_q1[0]);
  end

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    have = (exp_q.size() > 0);
    if (have) e = exp_q.pop_front();
    if (rst) begin
      chk("rst_we", 64'(bus.write_enable), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    end else begin
      chk("ready0", 64'(bus.req0_ready), 64'(m_q0.size() < 2));
      chk("ready1", 64'(bus.req1_ready), 64'(m_q1.size() < 2));
      chk("busy", 64'(bus.busy), 64'(model_busy()));
      if (have) begin
        chk("we", 64'(bus.write_enable), 64'(e.we));
        chk("dest", 64'(bus.dest), 64'(e.e.dest));
        chk("data_in", 64'(bus.data_in), 64'(e.e.data));
      end else begin
        chk("idle_we", 64'(bus.write_enable), 64'd0);
        chk("idle_dest", 64'(bus.dest), 64'd0);
        chk("idle_data", 64'(bus.data_in), 64'd0);
      end
    end
    if (bus.write_enable === 1'b1) wlog.push_back('{bus.dest, bus.data_in});
  end

  task automatic drive0(input bit v, input int d, input logic [DATA_W-1:0] x);
    bus.req0_valid = v;
    bus.req0_dest  = ADDR_W'(d);
    bus.req0_data  = x;
  endtask

  task automatic drive1(input bit v, input int d, input logic [DATA_W-1:0] x);
    bus.req1_valid = v;
    bus.req1_dest  = ADDR_W'(d);
    bus.req1_data  = x;
  endtask

  // Sample ready just before the edge, then advance past it.
  task automatic step();
    #1;
    rdy0_s = bus.req0_ready;
    rdy1_s = bus.req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    drive0(0, 0, '0);
    drive1(0, 0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc0, acc1, drop_at, n9;
    drive0(0, 0, '0);
    drive1(0, 0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    at_mid();
    chk("ready_after_rst", 64'({bus.req0_ready, bus.req1_ready}), 64'b11);
    chk("reset_busy", 64'(bus.busy), 64'd0);

    // Single write, 1-cycle latency, no bypass.
    reset_pulse();
    drive0(1, 3, 32'hDEADBEEF);
    at_mid();
    chk("t1_nobypass_we", 64'(bus.write_enable), 64'd0);
    chk("t1_nobypass_busy3", 64'(bus.busy[3]), 64'd0);
    @(posedge clk); #1;
    drive0(0, 0, '0);
    at_mid();
    chk("t1_we", 64'(bus.write_enable), 64'd1);
    chk("t1_dest", 64'(bus.dest), 64'd3);
    chk("t1_data", 64'(bus.data_in), 64'hDEADBEEF);
    chk("t1_busy3", 64'(bus.busy[3]), 64'd1);
    at_mid();
    chk("t1_we_after", 64'(bus.write_enable), 64'd0);
    chk("t1_busy3_after", 64'(bus.busy[3]), 64'd0);

    // Simultaneous pairs alternate starting with requester 0.
    reset_pulse();
    wlog.delete();
    drive0(1, 1, 32'h11); drive1(1, 2, 32'h22); step();
    drive0(0, 0, '0); drive1(0, 0, '0);
    repeat (3) step();
    drive0(1, 1, 32'h11); drive1(1, 2, 32'h22); step();
    drive0(0, 0, '0); drive1(0, 0, '0);
    repeat (4) step();
    chk("t2_count", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      chk("t2_w0", 64'(wlog[0].dest), 64'd1);
      chk("t2_w1", 64'(wlog[1].dest), 64'd2);
      chk("t2_w2", 64'(wlog[2].dest), 64'd1);
      chk("t2_w3", 64'(wlog[3].dest), 64'd2);
    end

    // Load unit backpressure under continuous ALU traffic.
    reset_pulse();
    wlog.delete();
    acc0 = 0; acc1 = 0; drop_at = -1;
    for (int cyc = 0; cyc < 40 && acc1 < 4; cyc++) begin
      drive0(1, 5, 32'hA000 + acc0);
      drive1(1, 9, 32'hB0 + acc1);
      step();
      if (rdy0_s) acc0++;
      if (rdy1_s) acc1++;
      else if (drop_at < 0) drop_at = acc1;
    end
    drive0(0, 0, '0); drive1(0, 0, '0);
    repeat (8) step();
    chk("t3_ready_drop_after", 64'(drop_at), 64'd2);
    chk("t3_accepts", 64'(acc1), 64'd4);
    n9 = 0;
    foreach (wlog[i]) begin
      if (wlog[i].dest == 4'd9) begin
        chk("t3_order", 64'(wlog[i].data), 64'(32'hB0 + n9));
        n9++;
      end
    end
    chk("t3_writes", 64'(n9), 64'd4);

    // Reset while queues are loaded drops everything.
    reset_pulse();
    acc0 = 0; acc1 = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive0(1, 6, 32'hC0 + acc0);
      drive1(1, 8, 32'hD0 + acc1);
      step();
      if (rdy0_s) acc0++;
      if (rdy1_s) acc1++;
    end
    chk("t4_one_full", 64'(rdy0_s & rdy1_s), 64'd0);
    wlog.delete();
    rst = 1'b1;
    drive0(0, 0, '0); drive1(0, 0, '0);
    at_mid();
    chk("t4_rst_we", 64'(bus.write_enable), 64'd0);
    chk("t4_rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    at_mid();
    chk("t4_rst_busy2", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive0(1, 4, 32'h1234); step();
    drive0(0, 0, '0);
    at_mid();
    chk("t4_post_we", 64'(bus.write_enable), 64'd1);
    chk("t4_post_dest", 64'(bus.dest), 64'd4);
    chk("t4_post_data", 64'(bus.data_in), 64'h1234);
    repeat (3) step();
    chk("t4_log", 64'(wlog.size()), 64'd1);

    // Register 0 handling.
    reset_pulse();
    drive0(1, 0, 32'h55); step();
    drive0(1, 7, 32'h77);
    at_mid();
    if (ZERO_EN) begin
      chk("t5_r0_we", 64'(bus.write_enable), 64'd0);
      chk("t5_r0_busy0", 64'(bus.busy[0]), 64'd0);
    end else begin
      chk("t5_r0_we", 64'(bus.write_enable), 64'd1);
      chk("t5_r0_dest", 64'(bus.dest), 64'd0);
      chk("t5_r0_data", 64'(bus.data_in), 64'h55);
      chk("t5_r0_busy0", 64'(bus.busy[0]), 64'd1);
    end
    @(posedge clk); #1;
    drive0(0, 0, '0);
    at_mid();
    chk("t5_next_we", 64'(bus.write_enable), 64'd1);
    chk("t5_next_dest", 64'(bus.dest), 64'd7);
    chk("t5_next_data", 64'(bus.data_in), 64'h77);

    // Randomized traffic with occasional resets, checked by the scoreboard.
    reset_pulse();
    for (int cyc = 0; cyc < 500; cyc++) begin
      drive0(($urandom % 4) != 0, int'($urandom % NREG), $urandom);
      drive1(($urandom % 3) != 0, int'($urandom % NREG), $urandom);
      rst = (($urandom % 60) == 0);
      step();
    end
    rst = 1'b0;
    drive0(0, 0, '0); drive1(0, 0, '0);
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
